axi4_mem_ctrl: RTL and testbench
================================

AXI4_MEM_CTRL -- requirements
Module: axi4_mem_ctrl

Interface
REQ-001 DATA_WIDTH, 32, data bus width in bits; only 32 SHALL be supported.
REQ-002 ADDR_WIDTH, 16, byte-address width.
REQ-003 MEMORY_DEPTH, 1024, number of DATA_WIDTH-bit words in the internal array.
REQ-004 ACLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 ARESETn  input  1  reset, synchronous and active-low.
REQ-006 AWADDR  input  ADDR_WIDTH  write burst start byte address.
REQ-007 AWLEN  input  8  write beats minus 1.
REQ-008 AWSIZE  input  3  write beat size, log2 bytes.
REQ-009 AWVALID  input  1  write address valid.
REQ-010 AWREADY  output  1  write address accepted.
REQ-011 WDATA  input  DATA_WIDTH  write beat data.
REQ-012 WVALID  input  1  write data valid.
REQ-013 WREADY  output  1  write data accepted.
REQ-014 WLAST  input  1  final write beat marker.
REQ-015 BRESP  output  2  write response: 00 OKAY, 10 SLVERR.
REQ-016 BVALID  output  1  write response valid.
REQ-017 BREADY  input  1  write response accepted.
REQ-018 ARADDR  input  ADDR_WIDTH  read burst start byte address.
REQ-019 ARLEN  input  8  read beats minus 1.
REQ-020 ARSIZE  input  3  read beat size, log2 bytes.
REQ-021 ARVALID  input  1  read address valid.
REQ-022 ARREADY  output  1  read address accepted.
REQ-023 RDATA  output  DATA_WIDTH  read beat data.
REQ-024 RRESP  output  2  read response: 00 OKAY, 10 SLVERR.
REQ-025 RLAST  output  1  final read beat marker.
REQ-026 RVALID  output  1  read data valid.
REQ-027 RREADY  input  1  read data accepted.

Function
REQ-028 All outputs SHALL be registered; the write FSM and the read FSM SHALL run independently and concurrently.
REQ-029 Write FSM states W_IDLE, W_DATA, W_RESP: AWREADY=1 only in W_IDLE; on AWVALID&&AWREADY latch word index AWADDR>>2, AWLEN, error flag, beat count 0, and go to W_DATA, with AWREADY low the next cycle.
REQ-030 In W_DATA, WREADY=1; each WVALID&&WREADY beat writes mem[idx] when the error flag is clear, then increments idx and count; the beat with count==AWLEN goes to W_RESP with WREADY low the next cycle.
REQ-031 In W_RESP, BVALID=1 and BRESP is held stable until BREADY; on BVALID&&BREADY go to W_IDLE with BVALID=0 the next cycle.
REQ-032 Read FSM states R_IDLE, R_DATA: ARREADY=1 only in R_IDLE; an AR handshake latches the same fields and asserts RVALID the next cycle with beat 0.
REQ-033 In R_DATA, RDATA, RRESP and RLAST SHALL hold stable while RVALID&&!RREADY; each handshake presents the next beat the following cycle; RLAST=1 only when count==ARLEN; the last handshake returns to R_IDLE with RVALID=0.
REQ-034 Error flag set (SLVERR) when SIZE!=2 or start_idx+LEN >= MEMORY_DEPTH, computed at ADDR_WIDTH+1 bits so it cannot wrap.
REQ-035 On an error burst, all beats SHALL still be handshaken, writes discarded, read beats return RDATA=0 with RRESP=10 on every beat.
REQ-036 WLAST asserted on a non-final beat, or deasserted on the final beat, SHALL force BRESP=10; burst length is always taken from AWLEN, and write data is still committed.
REQ-037 A read and a write to the same word in the same cycle SHALL return the old data (read-before-write).
REQ-038 Memory contents SHALL NOT be reset or initialised by the block.

Reset
REQ-039 While ARESETn=0 at a rising edge, FSMs go idle and AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST =0, BRESP and RRESP =00, RDATA=0; the first edge with ARESETn=1 sets AWREADY=ARREADY=1.
REQ-040 Reset mid-burst SHALL abandon the burst with no B or R response; beats already accepted remain written.

Verification
REQ-041 Reset held 2 cycles -> all outputs 0; one cycle after release AWREADY=ARREADY=1.
REQ-042 AW 0x0010/LEN 0/SIZE 2, WDATA 0xDEADBEEF WLAST=1 -> BRESP=00; AR 0x0010/LEN 0 -> RDATA 0xDEADBEEF, RLAST=1, RRESP=00.
REQ-043 Write 4 beats 1..4 at 0x0100; read ARLEN=3 with RREADY toggling 1,0,1,0 -> data 1,2,3,4, stable during stalls, RLAST on beat 4 only.
REQ-044 AW 0x0FFC LEN 1 -> 2 beats accepted, BRESP=10, mem[1023] unchanged; AR same -> RRESP=10, RDATA=0 on both beats; ARSIZE=1 -> RRESP=10.
REQ-045 4-beat write with WLAST on beat 2 -> 4 beats accepted, BRESP=10.
REQ-046 Reset after 2 of 4 write beats -> BVALID never asserts; AWREADY=1 after release; a read of those 2 words returns the written data.

Source files
------------

// File: rtl/axi4_mem_ctrl_if.sv
// AXI4 bus bundle for the memory controller: AW/W/B write channels and AR/R read channels.
interface axi4_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic                  WLAST;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WVALID, WLAST, BREADY,
           ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WVALID, WLAST, BREADY,
           ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi4_mem_ctrl.sv
// AXI4 slave backed by an internal word array; independent write and read burst engines,
// all outputs registered, SLVERR for bad size / out-of-range bursts and WLAST misplacement.
module axi4_mem_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  axi4_mem_ctrl_if.slave  bus
);

  localparam int MW = $clog2(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  wstate_t         w_state, w_next;
  logic [MW-1:0]   w_idx;
  logic [7:0]      w_len, w_cnt;
  logic            w_err, w_lerr;
  logic            aw_hs, w_hs, w_final;
  logic [ADDR_WIDTH-1:0] aw_word, ar_word;

  rstate_t         r_state, r_next;
  logic [MW-1:0]   r_idx, r_idx_nxt;
  logic [7:0]      r_len, r_cnt;
  logic            r_err, ar_err, ar_hs, r_hs;

  // Last word is computed one bit wider than the address so a huge LEN cannot wrap into range.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] word,
                                     input logic [7:0] len, input logic [2:0] size);
    logic [ADDR_WIDTH:0] last_word;
    last_word = {1'b0, word} + {{(ADDR_WIDTH-7){1'b0}}, len};
    return (size != 3'd2) || (last_word >= DEPTH);
  endfunction

  assign aw_word   = bus.AWADDR >> 2;
  assign ar_word   = bus.ARADDR >> 2;
  assign aw_hs     = bus.AWVALID && bus.AWREADY;
  assign w_hs      = bus.WVALID && bus.WREADY;
  assign w_final   = (w_cnt == w_len);
  assign ar_hs     = bus.ARVALID && bus.ARREADY;
  assign r_hs      = bus.RVALID && bus.RREADY;
  assign ar_err    = burst_err(ar_word, bus.ARLEN, bus.ARSIZE);
  assign r_idx_nxt = r_idx + MW'(1);

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs)                 w_next = W_DATA;
      W_DATA:  if (w_hs && w_final)       w_next = W_RESP;
      W_RESP:  if (bus.BVALID && bus.BREADY) w_next = W_IDLE;
      default:                            w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state     <= W_IDLE;
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= '0;
      w_idx       <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_err       <= 1'b0;
      w_lerr      <= 1'b0;
    end else begin
      w_state     <= w_next;
      bus.AWREADY <= (w_next == W_IDLE);
      bus.WREADY  <= (w_next == W_DATA);
      bus.BVALID  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_idx  <= aw_word[MW-1:0];
        w_len  <= bus.AWLEN;
        w_cnt  <= '0;
        w_err  <= burst_err(aw_word, bus.AWLEN, bus.AWSIZE);
        w_lerr <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= w_idx + MW'(1);
        w_cnt <= w_cnt + 8'd1;
        if (bus.WLAST != w_final) w_lerr <= 1'b1;
        if (w_final)
          bus.BRESP <= (w_err || w_lerr || !bus.WLAST) ? 2'b10 : 2'b00;
      end
    end
  end

  // Unreset array; nonblocking update gives read-before-write against the read engine.
  always_ff @(posedge ACLK) begin
    if (ARESETn && w_hs && !w_err) mem[w_idx] <= bus.WDATA;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)                    r_next = R_DATA;
      R_DATA:  if (r_hs && r_cnt == r_len)   r_next = R_IDLE;
      default:                               r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state     <= R_IDLE;
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RLAST   <= 1'b0;
      bus.RRESP   <= '0;
      bus.RDATA   <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= r_next;
      bus.ARREADY <= (r_next == R_IDLE);
      bus.RVALID  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_idx     <= ar_word[MW-1:0];
        r_len     <= bus.ARLEN;
        r_cnt     <= '0;
        r_err     <= ar_err;
        bus.RDATA <= ar_err ? '0 : mem[ar_word[MW-1:0]];
        bus.RRESP <= ar_err ? 2'b10 : 2'b00;
        bus.RLAST <= (bus.ARLEN == 8'd0);
      end else if (r_hs) begin
        if (r_cnt == r_len) begin
          bus.RLAST <= 1'b0;
        end else begin
          r_idx     <= r_idx_nxt;
          r_cnt     <= r_cnt + 8'd1;
          bus.RDATA <= r_err ? '0 : mem[r_idx_nxt];
          bus.RLAST <= (r_cnt + 8'd1 == r_len);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// Directed and randomized bursts against axi4_mem_ctrl, checked against a word-array reference model.
module tb_axi4_mem_ctrl;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_mem_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axi4_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [1024];
  bit          known   [1024];
  logic [31:0] wbuf    [256];
  logic        wlbuf   [256];
  logic [31:0] rd_d    [256];
  logic [1:0]  rd_r    [256];
  logic        rd_l    [256];
  logic [1:0]  last_bresp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input int addr, input int len, input int size);
    return (size != 2) || ((addr / 4) + len >= 1024);
  endfunction

  // beats < 0 runs the whole burst including the B phase; otherwise stops after that many beats.
  task automatic write_burst(input int addr, input int len, input int size, input int beats);
    int  n;
    int  nb;
    int  stall;
    bit  err;
    bit  lbad;
    err  = model_err(addr, len, size);
    lbad = 1'b0;
    @(negedge ACLK);
    bus.AWADDR = 16'(addr); bus.AWLEN = 8'(len); bus.AWSIZE = 3'(size); bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("awready", 64'(bus.AWREADY), 64'(1));
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    nb = (beats < 0) ? len + 1 : beats;
    for (int i = 0; i < nb; i++) begin
      bus.WDATA = wbuf[i]; bus.WLAST = wlbuf[i]; bus.WVALID = 1'b1;
      n = 0;
      while (!bus.WREADY && n < 50) begin @(negedge ACLK); n++; end
      chk("wready", 64'(bus.WREADY), 64'(1));
      if (wlbuf[i] != (i == len)) lbad = 1'b1;
      if (!err) begin
        ref_mem[addr / 4 + i] = wbuf[i];
        known[addr / 4 + i]   = 1'b1;
      end
      @(negedge ACLK);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    if (beats < 0) begin
      chk("wready_after_last", 64'(bus.WREADY), 64'(0));
      n = 0;
      while (!bus.BVALID && n < 50) begin @(negedge ACLK); n++; end
      chk("bvalid", 64'(bus.BVALID), 64'(1));
      last_bresp = bus.BRESP;
      chk("bresp", 64'(bus.BRESP), (err || lbad) ? 64'(2) : 64'(0));
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        @(negedge ACLK);
        chk("bresp_hold", 64'({bus.BVALID, bus.BRESP}), 64'({1'b1, last_bresp}));
      end
      bus.BREADY = 1'b1;
      @(negedge ACLK);
      bus.BREADY = 1'b0;
      chk("bvalid_clear", 64'(bus.BVALID), 64'(0));
    end
  endtask

  // mode 0: RREADY held high, 1: toggles 1,0,1,0..., 2: random.
  task automatic read_burst(input int addr, input int len, input int size, input int mode);
    int          n;
    int          k;
    int          cyc;
    int          w;
    bit          stalled;
    bit          err;
    logic        rr;
    logic [34:0] held;
    err = model_err(addr, len, size);
    @(negedge ACLK);
    bus.ARADDR = 16'(addr); bus.ARLEN = 8'(len); bus.ARSIZE = 3'(size); bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("arready", 64'(bus.ARREADY), 64'(1));
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k <= len && cyc < 2000) begin
      if (bus.RVALID) begin
        if (stalled)
          chk("r_hold", 64'({bus.RLAST, bus.RRESP, bus.RDATA}), 64'(held));
        rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
        bus.RREADY = rr;
        if (rr) begin
          rd_d[k] = bus.RDATA; rd_r[k] = bus.RRESP; rd_l[k] = bus.RLAST;
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {bus.RLAST, bus.RRESP, bus.RDATA};
        end
      end else begin
        bus.RREADY = 1'b0;
      end
      cyc++;
      @(negedge ACLK);
    end
    bus.RREADY = 1'b0;
    chk("r_beats", 64'(k), 64'(len + 1));
    chk("rvalid_end", 64'(bus.RVALID), 64'(0));
    for (int i = 0; i < k; i++) begin
      chk("rresp", 64'(rd_r[i]), err ? 64'(2) : 64'(0));
      chk("rlast", 64'(rd_l[i]), 64'(i == len));
      w = addr / 4 + i;
      if (err) chk("rdata_err", 64'(rd_d[i]), 64'(0));
      else if (known[w]) chk("rdata", 64'(rd_d[i]), 64'(ref_mem[w]));
    end
  endtask

  initial begin
    int  n;
    int  len;
    int  size;
    int  word;
    bit  seen;
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    // reset held two cycles
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ready", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(0));
    chk("rst_valid", 64'({bus.BVALID, bus.RVALID, bus.RLAST}), 64'(0));
    chk("rst_resp",  64'({bus.BRESP, bus.RRESP}), 64'(0));
    chk("rst_rdata", 64'(bus.RDATA), 64'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_ready", 64'({bus.AWREADY, bus.ARREADY}), 64'(3));

    // single beat write then read
    wbuf[0] = 32'hDEADBEEF; wlbuf[0] = 1'b1;
    write_burst(16'h0010, 0, 2, -1);
    chk("single_bresp", 64'(last_bresp), 64'(0));
    read_burst(16'h0010, 0, 2, 0);
    chk("single_rdata", 64'(rd_d[0]), 64'(32'hDEADBEEF));

    // 4-beat burst, read back with RREADY toggling
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); wlbuf[i] = (i == 3); end
    write_burst(16'h0100, 3, 2, -1);
    read_burst(16'h0100, 3, 2, 1);
    chk("burst4_d3", 64'(rd_d[3]), 64'(4));

    // top-of-memory boundary and size errors
    wbuf[0] = 32'hA5A50001; wlbuf[0] = 1'b1;
    write_burst(16'h0FFC, 0, 2, -1);
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wlbuf[0] = 1'b0; wlbuf[1] = 1'b1;
    write_burst(16'h0FFC, 1, 2, -1);
    chk("oob_bresp", 64'(last_bresp), 64'(2));
    read_burst(16'h0FFC, 0, 2, 0);
    chk("oob_unchanged", 64'(rd_d[0]), 64'(32'hA5A50001));
    read_burst(16'h0FFC, 1, 2, 0);
    read_burst(16'h0010, 0, 1, 0);
    chk("size_rresp", 64'(rd_r[0]), 64'(2));

    // WLAST on beat 2 of 4: all beats taken, SLVERR, data still committed
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE0000 + 32'(i); wlbuf[i] = (i == 1); end
    write_burst(16'h0200, 3, 2, -1);
    chk("wlast_bresp", 64'(last_bresp), 64'(2));
    read_burst(16'h0200, 3, 2, 2);

    // randomized bursts
    for (int t = 0; t < 24; t++) begin
      len  = $urandom_range(0, 7);
      size = ($urandom_range(0, 7) == 0) ? 1 : 2;
      word = ($urandom_range(0, 3) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1015);
      for (int i = 0; i <= len; i++) begin
        wbuf[i]  = $urandom;
        wlbuf[i] = (i == len) ^ ($urandom_range(0, 15) == 0);
      end
      write_burst(word * 4, len, size, -1);
      read_burst(word * 4, len, 2, 2);
    end

    // reset in the middle of a 4-beat write
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hBEEF0000 + 32'(i); wlbuf[i] = (i == 3); end
    write_burst(16'h0300, 3, 2, 2);
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("midrst_awready", 64'(bus.AWREADY), 64'(1));
    seen = 1'b0;
    for (n = 0; n < 8; n++) begin
      if (bus.BVALID) seen = 1'b1;
      @(negedge ACLK);
    end
    chk("midrst_no_b", 64'(seen), 64'(0));
    read_burst(16'h0300, 1, 2, 0);
    chk("midrst_w0", 64'(rd_d[0]), 64'(32'hBEEF0000));
    chk("midrst_w1", 64'(rd_d[1]), 64'(32'hBEEF0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
